// File: rtl/sm_sub_sequencer_pkg.sv
// Shared definitions for the sign-magnitude subtract sequencer.
//   state_t   : sequencer FSM states (await A, await B, result held)
//   N_DEFAULT : default operand/result width
//   sm_sign   : sign field (bit n-1) of an n-bit sign-magnitude word
//   sm_mag    : magnitude field (bits n-2:0) of an n-bit sign-magnitude word
// The helpers take the word zero-extended to 64 bits plus its width, so any
// N up to 64 can share them; callers truncate the result to their own width.
package sm_sub_sequencer_pkg;

  localparam int unsigned N_DEFAULT = 8;

  typedef enum logic [1:0] {
    S_A,
    S_B,
    S_OUT
  } state_t;

  function automatic logic sm_sign(input logic [63:0] w, input int unsigned n);
    return |(w & (64'd1 << (n - 1)));
  endfunction

  function automatic logic [63:0] sm_mag(input logic [63:0] w, input int unsigned n);
    return w & ((64'd1 << (n - 1)) - 64'd1);
  endfunction

endpackage

// File: rtl/sm_sub_sequencer_sub.sv
// Combinational sign-magnitude subtractor: computes A-B.
//   a, b  : N-bit sign-magnitude operands
//   sign  : raw result sign (may describe a negative zero)
//   mag   : raw N-1 bit result magnitude (wrapped on overflow)
//   carry : magnitude overflow (only possible when operand signs differ)
// Saturation and zero normalisation are applied by the caller.
module sm_sub_sequencer_sub
  import sm_sub_sequencer_pkg::*;
#(
  parameter int unsigned N = N_DEFAULT
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         sign,
  output logic [N-2:0] mag,
  output logic         carry
);

  localparam int unsigned MW = N - 1;

  logic          sa;
  logic          sb;
  logic [N-2:0]  ma;
  logic [N-2:0]  mb;
  logic [N-1:0]  sum;

  assign sa  = sm_sign(64'(a), N);
  assign sb  = sm_sign(64'(b), N);
  assign ma  = MW'(sm_mag(64'(a), N));
  assign mb  = MW'(sm_mag(64'(b), N));
  assign sum = {1'b0, ma} + {1'b0, mb};

  always_comb begin
    sign  = sa;
    mag   = '0;
    carry = 1'b0;
    if (sa == sb) begin
      // Same signs: subtract the smaller magnitude from the larger one;
      // the sign flips when B dominates.
      if (ma >= mb) begin
        mag  = ma - mb;
        sign = sa;
      end else begin
        mag  = mb - ma;
        sign = ~sa;
      end
    end else begin
      mag   = sum[N-2:0];
      carry = sum[N-1];
      sign  = sa;
    end
  end

endmodule

// File: rtl/sm_sub_sequencer.sv
// Two-operand sign-magnitude subtract sequencer.
// Accepts A then B on a valid/ready input, registers A-B and holds it on a
// valid/ready output until taken, counting completed output handshakes.
//   i_clk, i_rst_n     : clock, asynchronous active-low reset
//   i_data, i_valid    : operand input (A first, then B)
//   o_ready            : operand accepted this cycle (S_A, S_B)
//   o_result, o_carry  : registered A-B and magnitude overflow flag
//   o_valid, i_ready   : result handshake
//   i_flush            : synchronous abort, back to S_A, A cleared
//   o_op_cnt           : completed output handshakes, wraps at 256
// Build option: define SM_SUB_SAT_EN to saturate the magnitude to all ones
// on overflow (sign kept, o_carry still 1); otherwise the magnitude wraps.
module sm_sub_sequencer
  import sm_sub_sequencer_pkg::*;
#(
  parameter int unsigned N = N_DEFAULT
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [N-1:0] i_data,
  input  logic         i_valid,
  output logic         o_ready,
  output logic [N-1:0] o_result,
  output logic         o_carry,
  output logic         o_valid,
  input  logic         i_ready,
  input  logic         i_flush,
  output logic [7:0]   o_op_cnt
);

  state_t        state;
  state_t        state_next;
  logic [N-1:0]  a_reg;
  logic          a_load;
  logic          a_clear;
  logic          res_load;
  logic          cnt_inc;

  logic          sub_sign;
  logic [N-2:0]  sub_mag;
  logic          sub_carry;
  logic [N-2:0]  mag_fin;
  logic [N-1:0]  result_next;

  sm_sub_sequencer_sub #(
    .N(N)
  ) u_sub (
    .a    (a_reg),
    .b    (i_data),
    .sign (sub_sign),
    .mag  (sub_mag),
    .carry(sub_carry)
  );

  // Saturation then zero normalisation; a zero magnitude is always +0.
  always_comb begin
    mag_fin = sub_mag;
`ifdef SM_SUB_SAT_EN
    if (sub_carry) begin
      mag_fin = '1;
    end
`endif
    if (mag_fin == '0) begin
      result_next = '0;
    end else begin
      result_next = {sub_sign, mag_fin};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= S_A;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    a_load     = 1'b0;
    a_clear    = 1'b0;
    res_load   = 1'b0;
    cnt_inc    = 1'b0;
    o_ready    = 1'b0;
    o_valid    = 1'b0;
    case (state)
      S_A: begin
        o_ready = 1'b1;
        if (i_valid) begin
          a_load     = 1'b1;
          state_next = S_B;
        end
      end
      S_B: begin
        o_ready = 1'b1;
        if (i_valid) begin
          res_load   = 1'b1;
          state_next = S_OUT;
        end
      end
      S_OUT: begin
        o_valid = 1'b1;
        if (i_ready) begin
          cnt_inc    = 1'b1;
          state_next = S_A;
        end
      end
      default: state_next = S_A;
    endcase
    // Flush wins over any coincident handshake in either direction.
    if (i_flush) begin
      state_next = S_A;
      a_load     = 1'b0;
      res_load   = 1'b0;
      cnt_inc    = 1'b0;
      a_clear    = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      a_reg <= '0;
    end else if (a_clear) begin
      a_reg <= '0;
    end else if (a_load) begin
      a_reg <= i_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_result <= '0;
      o_carry  <= 1'b0;
    end else if (res_load) begin
      o_result <= result_next;
      o_carry  <= sub_carry;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_op_cnt <= '0;
    end else if (cnt_inc) begin
      o_op_cnt <= o_op_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_sm_sub_sequencer.sv
// Directed self-checking bench for sm_sub_sequencer (N = 8).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_sm_sub_sequencer;

  logic       i_clk;
  logic       i_rst_n;
  logic [7:0] i_data;
  logic       i_valid;
  logic       o_ready;
  logic [7:0] o_result;
  logic       o_carry;
  logic       o_valid;
  logic       i_ready;
  logic       i_flush;
  logic [7:0] o_op_cnt;

  int unsigned n_cmp;
  int unsigned n_err;

  sm_sub_sequencer #(
    .N(8)
  ) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_data  (i_data),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .o_result(o_result),
    .o_carry (o_carry),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .i_flush (i_flush),
    .o_op_cnt(o_op_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present A then B on consecutive cycles; ends at the falling edge where
  // the result is first visible (one cycle after the B handshake).
  task automatic do_op(input logic [7:0] a, input logic [7:0] b);
    i_valid = 1'b1;
    i_data  = a;
    @(negedge i_clk);
    check("o_valid_before_b", o_valid, 0);
    i_data = b;
    @(negedge i_clk);
    i_valid = 1'b0;
    check("o_valid_after_b", o_valid, 1);
  endtask

  task automatic take();
    i_ready = 1'b1;
    @(negedge i_clk);
    i_ready = 1'b0;
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    i_rst_n = 1'b0;
    i_data  = '0;
    i_valid = 1'b0;
    i_ready = 1'b0;
    i_flush = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
    check("rst_valid",  o_valid,  0);
    check("rst_result", o_result, 0);
    check("rst_carry",  o_carry,  0);
    check("rst_cnt",    o_op_cnt, 0);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    check("rst_ready", o_ready, 1);

    // +5 - +3 = +2
    do_op(8'h05, 8'h03);
    check("r1_result", o_result, 8'h02);
    check("r1_carry",  o_carry,  0);
    check("r1_ready",  o_ready,  0);
    check("r1_cnt",    o_op_cnt, 0);
    take();
    check("r1_cnt_after", o_op_cnt, 1);
    check("r1_valid_after", o_valid, 0);
    check("r1_ready_after", o_ready, 1);

    // +3 - +5 = -2
    do_op(8'h03, 8'h05);
    check("r2_result", o_result, 8'h82);
    check("r2_carry",  o_carry,  0);
    take();

    // +100 - -100 = +200 overflows the 7-bit magnitude
    do_op(8'h64, 8'hE4);
    check("r3_carry", o_carry, 1);
`ifdef SM_SUB_SAT_EN
    check("r3_result", o_result, 8'h7F);
`else
    check("r3_result", o_result, 8'h48);
`endif
    take();

    // -5 - -5 = 0, no negative zero
    do_op(8'h85, 8'h85);
    check("r4_result", o_result, 8'h00);
    check("r4_carry",  o_carry,  0);
    take();

    // -0 - +0 = -0 normalised to +0
    do_op(8'h80, 8'h00);
    check("r5_result", o_result, 8'h00);
    check("r5_carry",  o_carry,  0);
    take();

    // -0 - -5 = +5
    do_op(8'h80, 8'h85);
    check("r6_result", o_result, 8'h05);
    take();
    check("r6_cnt", o_op_cnt, 6);

    // +16 - -16 = +32, held with i_ready low while new input is offered
    do_op(8'h10, 8'h90);
    i_valid = 1'b1;
    i_data  = 8'h77;
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      check("hold_result", o_result, 8'h20);
      check("hold_valid",  o_valid,  1);
      check("hold_ready",  o_ready,  0);
    end
    i_valid = 1'b0;
    check("hold_cnt", o_op_cnt, 6);
    take();
    check("hold_cnt_after", o_op_cnt, 7);
    check("hold_ready_after", o_ready, 1);

    // Flush while in S_B with a coincident B handshake
    i_valid = 1'b1;
    i_data  = 8'h05;
    @(negedge i_clk);
    i_data  = 8'h01;
    i_flush = 1'b1;
    @(negedge i_clk);
    i_valid = 1'b0;
    i_flush = 1'b0;
    check("flush_b_valid", o_valid, 0);
    check("flush_b_ready", o_ready, 1);
    check("flush_b_cnt",   o_op_cnt, 7);
    do_op(8'h02, 8'h01);
    check("post_flush_result", o_result, 8'h01);
    take();
    check("post_flush_cnt", o_op_cnt, 8);

    // Flush in S_OUT overrides a coincident output handshake
    do_op(8'h07, 8'h02);
    check("r7_result", o_result, 8'h05);
    i_ready = 1'b1;
    i_flush = 1'b1;
    @(negedge i_clk);
    i_ready = 1'b0;
    i_flush = 1'b0;
    check("flush_out_valid", o_valid, 0);
    check("flush_out_cnt",   o_op_cnt, 8);

    // Reset pulse while a result is pending
    do_op(8'h09, 8'h01);
    check("r8_result", o_result, 8'h08);
    i_rst_n = 1'b0;
    @(negedge i_clk);
    check("mid_rst_valid",  o_valid,  0);
    check("mid_rst_result", o_result, 0);
    check("mid_rst_cnt",    o_op_cnt, 0);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    check("mid_rst_ready", o_ready, 1);

    // Counter wrap after 256 completed operations
    for (int k = 0; k < 255; k++) begin
      do_op(8'h01, 8'h01);
      take();
    end
    check("cnt_255", o_op_cnt, 255);
    do_op(8'h01, 8'h01);
    take();
    check("cnt_wrap", o_op_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
